// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the two-port data-memory arbiter.
package dmem_arb_pkg;

  localparam int DMEM_ADDR_W = 14;
  localparam int DMEM_DATA_W = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  typedef enum logic {
    PORT_0 = 1'b0,
    PORT_1 = 1'b1
  } port_id_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester's view of the arbiter: request/write bundle in, grant and read return out.
interface dmem_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W
);
  logic                  req;
  logic                  we;
  logic                  lock;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W/8-1:0]   be;
  logic [DATA_W-1:0]     wdata;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_W-1:0]     rdata;

  modport master (output req, we, lock, addr, be, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, lock, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/dmem_rd_tracker.sv
// Read-tag pipeline: carries {valid, port} alongside the memory's read latency.
module dmem_rd_tracker
  import dmem_arb_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push_valid,
  input  port_id_t push_port,
  output logic     out_valid,
  output port_id_t out_port
);

  logic [RD_LATENCY-1:0] vld;
  port_id_t              prt [RD_LATENCY];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      for (int i = 0; i < RD_LATENCY; i++) prt[i] <= PORT_0;
    end else begin
      vld[0] <= push_valid;
      prt[0] <= push_port;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld[i] <= vld[i-1];
        prt[i] <= prt[i-1];
      end
    end
  end

  assign out_valid = vld[RD_LATENCY-1];
  assign out_port  = prt[RD_LATENCY-1];

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing dmem between the SIMD core (p0) and an auxiliary master (p1).
// Optional DMEM_ARB_STATS_EN adds saturating conflict / aux-grant counters.
//
// state | meaning
// IDLE  | no lock held, round-robin between requesters
// OWN0  | port 0 holds a burst lock, only port 0 may be granted
// OWN1  | port 1 holds a burst lock, only port 1 may be granted
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int RD_LATENCY = 1,
  parameter int ADDR_W     = DMEM_ADDR_W,
  parameter int DATA_W     = DMEM_DATA_W
) (
  input  logic                clk,
  input  logic                reset,
  dmem_arbiter_if.slave       p0,
  dmem_arbiter_if.slave       p1,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteena,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_rden,
  output logic                mem_wren,
  input  logic [DATA_W-1:0]   mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]         stat_conflicts,
  output logic [15:0]         stat_aux_grants
`endif
);

  arb_state_t state;
  port_id_t   last_gnt;
  logic       gnt0;
  logic       gnt1;
  logic       trk_valid;
  port_id_t   trk_port;

  // Grant is combinational so the core sees a stall in the same cycle it asks.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (p0.req && p1.req) begin
            gnt0 = (last_gnt == PORT_1);
            gnt1 = (last_gnt == PORT_0);
          end else begin
            gnt0 = p0.req;
            gnt1 = p1.req;
          end
        end
        OWN0:    gnt0 = p0.req;
        OWN1:    gnt1 = p1.req;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      last_gnt <= PORT_1;
    end else if (gnt0) begin
      last_gnt <= PORT_0;
      state    <= p0.lock ? OWN0 : IDLE;
    end else if (gnt1) begin
      last_gnt <= PORT_1;
      state    <= p1.lock ? OWN1 : IDLE;
    end else begin
      // a lock owner that stops requesting gives the lock up
      state <= IDLE;
    end
  end

  always_comb begin
    mem_address = '0;
    mem_byteena = '0;
    mem_wdata   = '0;
    mem_rden    = 1'b0;
    mem_wren    = 1'b0;
    if (gnt0) begin
      mem_address = p0.addr;
      mem_byteena = p0.we ? p0.be : '1;
      mem_wdata   = p0.wdata;
      mem_rden    = ~p0.we;
      mem_wren    = p0.we;
    end else if (gnt1) begin
      mem_address = p1.addr;
      mem_byteena = p1.we ? p1.be : '1;
      mem_wdata   = p1.wdata;
      mem_rden    = ~p1.we;
      mem_wren    = p1.we;
    end
  end

  dmem_rd_tracker #(.RD_LATENCY(RD_LATENCY)) u_rd_tracker (
    .clk        (clk),
    .rst        (reset),
    .push_valid ((gnt0 & ~p0.we) | (gnt1 & ~p1.we)),
    .push_port  (gnt1 ? PORT_1 : PORT_0),
    .out_valid  (trk_valid),
    .out_port   (trk_port)
  );

  assign p0.gnt    = gnt0;
  assign p1.gnt    = gnt1;
  assign p0.rvalid = trk_valid && (trk_port == PORT_0);
  assign p1.rvalid = trk_valid && (trk_port == PORT_1);
  assign p0.rdata  = mem_rdata;
  assign p1.rdata  = mem_rdata;

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_conflicts  <= '0;
      stat_aux_grants <= '0;
    end else begin
      // with both asking, exactly one is always refused
      if (p0.req && p1.req && stat_conflicts != 16'hFFFF)
        stat_conflicts <= stat_conflicts + 16'd1;
      if (gnt1 && stat_aux_grants != 16'hFFFF)
        stat_aux_grants <= stat_aux_grants + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: vector table, directed corner sequences, random traffic vs a model.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int L  = 2;
  localparam int AW = 14;
  localparam int DW = 256;
  localparam int BW = DW / 8;

  typedef struct packed {
    logic          req;
    logic          we;
    logic          lock;
    logic [AW-1:0] addr;
    logic [BW-1:0] be;
    logic [DW-1:0] wdata;
  } req_t;

  typedef struct {
    req_t          s0;
    req_t          s1;
    logic          eg0;
    logic          eg1;
    logic          erd;
    logic          ewr;
    logic [AW-1:0] ea;
    logic [BW-1:0] ebe;
  } vec_t;

  typedef struct {
    int            due;
    int            port;
    logic [DW-1:0] data;
  } rd_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) p0 ();
  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) p1 ();

  logic [AW-1:0] mem_address;
  logic [BW-1:0] mem_byteena;
  logic [DW-1:0] mem_wdata;
  logic          mem_rden;
  logic          mem_wren;
  logic [DW-1:0] mem_rdata;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0]   stat_conflicts;
  logic [15:0]   stat_aux_grants;
`endif

  dmem_arbiter #(.RD_LATENCY(L), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk             (clk),
    .reset           (reset),
`ifdef DMEM_ARB_STATS_EN
    .stat_conflicts  (stat_conflicts),
    .stat_aux_grants (stat_aux_grants),
`endif
    .p0              (p0),
    .p1              (p1),
    .mem_address     (mem_address),
    .mem_byteena     (mem_byteena),
    .mem_wdata       (mem_wdata),
    .mem_rden        (mem_rden),
    .mem_wren        (mem_wren),
    .mem_rdata       (mem_rdata)
  );

  // dmem stand-in, 64 words, read data appears L edges after the read
  logic [DW-1:0] mem     [64] = '{default: '0};
  logic [DW-1:0] rd_pipe [L]  = '{default: '0};
  always @(posedge clk) begin
    if (mem_wren)
      for (int b = 0; b < BW; b++)
        if (mem_byteena[b]) mem[mem_address[5:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    rd_pipe[0] <= mem_rden ? mem[mem_address[5:0]] : '0;
    for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[L-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int            errors = 0;
  int            checks = 0;
  int            owner = -1;
  int            last = 1;
  logic [DW-1:0] shadow [64] = '{default: '0};
  rd_t           rq [$];
  int            gnt_log [$];
  int            rv_log [$];
  logic [DW-1:0] s_rd0;
  vec_t          vt [6];

  task automatic chkw(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic req_t idle_r();
    req_t r = '0;
    return r;
  endfunction

  function automatic req_t rd_r(input logic [AW-1:0] a, input logic lk = 1'b0);
    req_t r = '0;
    r.req  = 1'b1;
    r.addr = a;
    r.lock = lk;
    return r;
  endfunction

  function automatic req_t wr_r(input logic [AW-1:0] a, input logic [BW-1:0] be,
                                input logic [DW-1:0] d, input logic lk = 1'b0);
    req_t r = '0;
    r.req   = 1'b1;
    r.we    = 1'b1;
    r.addr  = a;
    r.be    = be;
    r.wdata = d;
    r.lock  = lk;
    return r;
  endfunction

  function automatic req_t rand_r();
    req_t r;
    r.req   = 1'($urandom_range(0, 1));
    r.we    = ($urandom_range(0, 2) == 0);
    r.lock  = ($urandom_range(0, 3) == 0);
    r.addr  = AW'($urandom_range(0, 15));
    r.be    = $urandom();
    r.wdata = {$urandom(), $urandom(), $urandom(), $urandom(),
               $urandom(), $urandom(), $urandom(), $urandom()};
    return r;
  endfunction

  // Who the rules say wins: a lock holder owns the memory, otherwise alternate on ties.
  function automatic int model_winner(input logic r0, input logic r1);
    if (owner == 0) return r0 ? 0 : -1;
    if (owner == 1) return r1 ? 1 : -1;
    if (r0 && r1) return (last == 0) ? 1 : 0;
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  task automatic drive(input req_t s0, input req_t s1);
    p0.req = s0.req; p0.we = s0.we; p0.lock = s0.lock;
    p0.addr = s0.addr; p0.be = s0.be; p0.wdata = s0.wdata;
    p1.req = s1.req; p1.we = s1.we; p1.lock = s1.lock;
    p1.addr = s1.addr; p1.be = s1.be; p1.wdata = s1.wdata;
  endtask

  task automatic step(input req_t s0, input req_t s1);
    int            w;
    int            c;
    req_t          ws;
    logic          e0;
    logic          e1;
    logic [DW-1:0] ed;
    @(negedge clk);
    drive(s0, s1);
    #1;
    c  = cyc;
    w  = model_winner(s0.req, s1.req);
    ws = (w == 1) ? s1 : s0;
    if (w < 0) ws = '0;
    chk1("gnt0", p0.gnt, w == 0);
    chk1("gnt1", p1.gnt, w == 1);
    chk1("mem_rden", mem_rden, ws.req && !ws.we);
    chk1("mem_wren", mem_wren, ws.req && ws.we);
    chkw("mem_address", DW'(mem_address), DW'(ws.addr));
    chkw("mem_byteena", DW'(mem_byteena), DW'(!ws.req ? '0 : (ws.we ? ws.be : {BW{1'b1}})));
    chkw("mem_wdata", mem_wdata, ws.wdata);
    e0 = 1'b0; e1 = 1'b0; ed = '0;
    if (rq.size() > 0 && rq[0].due == c) begin
      e0 = (rq[0].port == 0);
      e1 = (rq[0].port == 1);
      ed = rq[0].data;
      void'(rq.pop_front());
    end
    chk1("rvalid0", p0.rvalid, e0);
    chk1("rvalid1", p1.rvalid, e1);
    if (e0) chkw("rdata0", p0.rdata, ed);
    if (e1) chkw("rdata1", p1.rdata, ed);
    gnt_log.push_back(p0.gnt ? 0 : (p1.gnt ? 1 : -1));
    rv_log.push_back(p0.rvalid ? 0 : (p1.rvalid ? 1 : -1));
    s_rd0 = p0.rdata;
    if (w >= 0) begin
      last  = w;
      owner = ws.lock ? w : -1;
      if (ws.we) begin
        for (int b = 0; b < BW; b++)
          if (ws.be[b]) shadow[ws.addr[5:0]][b*8 +: 8] = ws.wdata[b*8 +: 8];
      end else begin
        rq.push_back('{c + L, w, shadow[ws.addr[5:0]]});
      end
    end else begin
      owner = -1;
    end
    @(posedge clk);
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(idle_r(), idle_r());
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    drive(rd_r(14'h10), rd_r(14'h11));
    reset = 1'b1;
    #1;
    chk1("rst_gnt0", p0.gnt, 1'b0);
    chk1("rst_gnt1", p1.gnt, 1'b0);
    chk1("rst_rden", mem_rden, 1'b0);
    chk1("rst_wren", mem_wren, 1'b0);
    chk1("rst_rvalid0", p0.rvalid, 1'b0);
    chk1("rst_rvalid1", p1.rvalid, 1'b0);
    chkw("rst_address", DW'(mem_address), '0);
    repeat (n) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    drive(idle_r(), idle_r());
    owner = -1;
    last  = 1;
    rq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    drive(idle_r(), idle_r());
    do_reset(2);

    // Mid-cycle mux vectors; requests drop before the edge so nothing is accepted.
    vt[0] = '{idle_r(), idle_r(), 1'b0, 1'b0, 1'b0, 1'b0, 14'h0, 32'h0};
    vt[1] = '{rd_r(14'h0010), idle_r(), 1'b1, 1'b0, 1'b1, 1'b0, 14'h0010, 32'hFFFF_FFFF};
    vt[2] = '{idle_r(), wr_r(14'h3FFF, 32'h0000_000F, {8{32'hDEAD_BEEF}}),
              1'b0, 1'b1, 1'b0, 1'b1, 14'h3FFF, 32'h0000_000F};
    vt[3] = '{wr_r(14'h0005, 32'hF0F0_F0F0, '1), rd_r(14'h0006),
              1'b1, 1'b0, 1'b0, 1'b1, 14'h0005, 32'hF0F0_F0F0};
    vt[4] = '{rd_r(14'h0007, 1'b1), rd_r(14'h0008, 1'b1),
              1'b1, 1'b0, 1'b1, 1'b0, 14'h0007, 32'hFFFF_FFFF};
    vt[5] = '{idle_r(), rd_r(14'h1234), 1'b0, 1'b1, 1'b1, 1'b0, 14'h1234, 32'hFFFF_FFFF};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(vt[i].s0, vt[i].s1);
      #1;
      chk1("tbl_gnt0", p0.gnt, vt[i].eg0);
      chk1("tbl_gnt1", p1.gnt, vt[i].eg1);
      chk1("tbl_rden", mem_rden, vt[i].erd);
      chk1("tbl_wren", mem_wren, vt[i].ewr);
      chkw("tbl_address", DW'(mem_address), DW'(vt[i].ea));
      chkw("tbl_byteena", DW'(mem_byteena), DW'(vt[i].ebe));
      #2;
      drive(idle_r(), idle_r());
    end

    // Continuous tie without lock alternates, port 0 first.
    gnt_log.delete();
    for (int i = 0; i < 4; i++) step(rd_r(14'h30), rd_r(14'h31));
    chki("alt_0", gnt_log[0], 0);
    chki("alt_1", gnt_log[1], 1);
    chki("alt_2", gnt_log[2], 0);
    chki("alt_3", gnt_log[3], 1);
    idle_steps(L);

    // Single read from port 0 returns stored data after L cycles.
    step(wr_r(14'h0010, '1, {8{32'hCAFE_0010}}), idle_r());
    rv_log.delete();
    step(rd_r(14'h0010), idle_r());
    idle_steps(L);
    chki("rd10_rvalid", rv_log[L], 0);
    chkw("rd10_data", s_rd0, {8{32'hCAFE_0010}});

    // Port 1 four-beat locked write burst while port 0 keeps asking.
    step(wr_r(14'h0020, '1, {32{8'hAA}}), idle_r());
    gnt_log.delete();
    step(idle_r(), wr_r(14'h0020, 32'h0000_000F, {32{8'h11}}, 1'b1));
    step(rd_r(14'h0021), wr_r(14'h0020, 32'h0000_000F, {32{8'h22}}, 1'b1));
    step(rd_r(14'h0021), wr_r(14'h0020, 32'h0000_000F, {32{8'h33}}, 1'b1));
    step(rd_r(14'h0021), wr_r(14'h0020, 32'h0000_000F, {32{8'h44}}, 1'b0));
    step(rd_r(14'h0021), idle_r());
    chki("lock_b1", gnt_log[0], 1);
    chki("lock_b2", gnt_log[1], 1);
    chki("lock_b3", gnt_log[2], 1);
    chki("lock_b4", gnt_log[3], 1);
    chki("lock_b5", gnt_log[4], 0);
    step(rd_r(14'h0020), idle_r());
    idle_steps(L);
    chkw("lock_bytes", s_rd0, {{28{8'hAA}}, {4{8'h44}}});

    // Lock holder goes quiet: nobody granted that cycle, the other port next.
    gnt_log.delete();
    step(idle_r(), rd_r(14'h0005, 1'b1));
    step(rd_r(14'h0006), idle_r());
    step(rd_r(14'h0006), idle_r());
    chki("rel_0", gnt_log[0], 1);
    chki("rel_1", gnt_log[1], -1);
    chki("rel_2", gnt_log[2], 0);
    idle_steps(L);

    // Back-to-back reads p0, p1, p0 return in order on consecutive cycles.
    step(wr_r(14'h1, '1, {8{32'h0000_0001}}), wr_r(14'h2, '1, {8{32'h0000_0002}}));
    step(idle_r(), wr_r(14'h2, '1, {8{32'h0000_0002}}));
    step(wr_r(14'h3, '1, {8{32'h0000_0003}}), idle_r());
    rv_log.delete();
    step(rd_r(14'h1), idle_r());
    step(idle_r(), rd_r(14'h2));
    step(rd_r(14'h3), idle_r());
    idle_steps(L);
    n = rv_log.size();
    chki("b2b_first", rv_log[n-3], 0);
    chki("b2b_second", rv_log[n-2], 1);
    chki("b2b_third", rv_log[n-1], 0);

    // Reset one cycle after an accepted read: that read never returns.
    step(rd_r(14'h1), idle_r());
    do_reset(2);
    rv_log.delete();
    idle_steps(L + 2);
    n = 0;
    foreach (rv_log[i]) if (rv_log[i] != -1) n++;
    chki("rst_no_rvalid", n, 0);

`ifdef DMEM_ARB_STATS_EN
    do_reset(1);
    for (int i = 0; i < 10; i++) step(rd_r(14'h8), rd_r(14'h9));
    #1;
    chki("stat_conflicts", int'(stat_conflicts), 10);
    chki("stat_aux_grants", int'(stat_aux_grants), 5);
    idle_steps(L);
`endif

    for (int i = 0; i < 400; i++) step(rand_r(), rand_r());
    idle_steps(L + 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
